// File: rtl/datapath_pkg.sv
// datapath_pkg: shared enums, reset constants and sign-extension helper for datapath_p.
package datapath_pkg;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} alu_op_e;
  typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDR, PC_HOLD} pcmux_e;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2_e;
  localparam logic [2:0] RESET_NZP = 3'b010;
  localparam int SEXT_MAX_W = 128;
  // Result is SEXT_MAX_W wide; callers size-cast it down to their WIDTH.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [15:0] value, input int unsigned from_width);
    logic [15:0] v;
    logic signed [SEXT_MAX_W-1:0] t;
    v = value << (16 - from_width);
    t = {v, {(SEXT_MAX_W-16){1'b0}}};
    return t >>> (SEXT_MAX_W - from_width);
  endfunction
endpackage

// File: rtl/datapath_p_regfile.sv
// regfile_p: 8 x WIDTH register file, one write port, two combinational read ports.
module regfile_p
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [2:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [2:0]       i_raddr1,
  input  logic [2:0]       i_raddr2,
  output logic [WIDTH-1:0] o_rdata1,
  output logic [WIDTH-1:0] o_rdata2
);
  logic [WIDTH-1:0] r_regs [8];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_regs <= '{default: '0};
    else if (i_we) r_regs[i_waddr] <= i_wdata;
  end
  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];
endmodule

// File: rtl/datapath_p.sv
// datapath_p: LC-3 datapath (PC/IR/MAR/MDR, regfile, ALU, address adder, NZP/BEN, LED).
// Define DATAPATH_BUSCHK_EN to add the sticky Bus_Err contention flag and its assertion.
module datapath_p
  import datapath_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter int               LED_W    = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             LD_LED,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic [1:0]       PCMUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic             MIO_EN,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic [WIDTH-1:0] MDR_In,
  output logic [WIDTH-1:0] Bus,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic             BEN,
  output logic [2:0]       NZP,
  output logic [LED_W-1:0] LED
`ifdef DATAPATH_BUSCHK_EN
  ,
  output logic             Bus_Err
`endif
);
  logic [WIDTH-1:0] r_pc, r_ir, r_mar, r_mdr;
  logic [LED_W-1:0] r_led;
  logic [2:0]       r_nzp;
  logic             r_ben;
  logic [2:0]       w_sr1, w_dr;
  logic [WIDTH-1:0] w_sr1_d, w_sr2_d, w_b, w_alu, w_addr1, w_addr2, w_adder, w_bus, w_pc_next;
  logic [2:0]       w_nzp;
  alu_op_e          w_aluk;
  addr2_e           w_a2sel;
  pcmux_e           w_pcsel;

  assign w_sr1 = SR1MUX ? r_ir[8:6] : r_ir[11:9];
  assign w_dr  = DRMUX ? 3'd7 : r_ir[11:9];

  regfile_p #(.WIDTH(WIDTH)) u_rf (
    .i_clk    (Clk),
    .i_rst_n  (Reset),
    .i_we     (LD_REG),
    .i_waddr  (w_dr),
    .i_wdata  (w_bus),
    .i_raddr1 (w_sr1),
    .i_raddr2 (r_ir[2:0]),
    .o_rdata1 (w_sr1_d),
    .o_rdata2 (w_sr2_d)
  );

  assign w_aluk = alu_op_e'(ALUK);
  assign w_b    = SR2MUX ? WIDTH'(sext(r_ir[15:0], 5)) : w_sr2_d;
  assign w_alu  = (w_aluk == ALU_ADD) ? w_sr1_d + w_b :
                  (w_aluk == ALU_AND) ? w_sr1_d & w_b :
                  (w_aluk == ALU_NOT) ? ~w_sr1_d : w_sr1_d;

  assign w_a2sel = addr2_e'(ADDR2MUX);
  assign w_addr1 = ADDR1MUX ? w_sr1_d : r_pc;
  assign w_addr2 = (w_a2sel == A2_ZERO) ? '0 :
                   (w_a2sel == A2_OFF6) ? WIDTH'(sext(r_ir[15:0], 6)) :
                   (w_a2sel == A2_OFF9) ? WIDTH'(sext(r_ir[15:0], 9)) :
                                          WIDTH'(sext(r_ir[15:0], 11));
  assign w_adder = w_addr1 + w_addr2;

  // Fixed priority PC > MDR > ALU > MARMUX resolves any gate contention.
  assign w_bus = GatePC     ? r_pc  :
                 GateMDR    ? r_mdr :
                 GateALU    ? w_alu :
                 GateMARMUX ? w_adder : '0;

  assign w_pcsel   = pcmux_e'(PCMUX);
  assign w_pc_next = (w_pcsel == PC_INC)  ? r_pc + 1'b1 :
                     (w_pcsel == PC_BUS)  ? w_bus :
                     (w_pcsel == PC_ADDR) ? w_adder : r_pc;

  assign w_nzp = w_bus[WIDTH-1] ? 3'b100 : (w_bus == '0) ? 3'b010 : 3'b001;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc  <= PC_RESET;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_led <= '0;
      r_nzp <= RESET_NZP;
      r_ben <= 1'b0;
    end else begin
      if (LD_PC)  r_pc  <= w_pc_next;
      if (LD_IR)  r_ir  <= w_bus;
      if (LD_MAR) r_mar <= w_bus;
      if (LD_MDR) r_mdr <= MIO_EN ? MDR_In : w_bus;
      if (LD_LED) r_led <= r_ir[LED_W-1:0];
      if (LD_CC)  r_nzp <= w_nzp;
      if (LD_BEN) r_ben <= |(r_ir[11:9] & r_nzp);
    end
  end

`ifdef DATAPATH_BUSCHK_EN
  logic       r_bus_err;
  logic [3:0] w_gates;
  assign w_gates = {GatePC, GateMDR, GateALU, GateMARMUX};
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_bus_err <= 1'b0;
    else if (!$onehot0(w_gates)) r_bus_err <= 1'b1;
  end
  assign Bus_Err = r_bus_err;
`ifndef SYNTHESIS
  a_bus_onehot: assert property (@(posedge Clk) disable iff (!Reset) $onehot0(w_gates))
    else $error("bus contention: gates=%b", w_gates);
`endif
`endif

  assign Bus = w_bus;
  assign MAR = r_mar;
  assign MDR = r_mdr;
  assign IR  = r_ir;
  assign PC  = r_pc;
  assign BEN = r_ben;
  assign NZP = r_nzp;
  assign LED = r_led;
endmodule

// File: tb/tb_datapath_p.sv
// tb_datapath_p: directed and randomized checks of datapath_p (16-bit and 32-bit instances).
module tb_datapath_p;
  localparam logic [15:0] PCR = 16'h3000;
  logic Clk = 1'b0, Reset = 1'b1;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [15:0] MDR_In, Bus, MAR, MDR, IR, PC;
  logic [31:0] MDR_In32, Bus32, MAR32, MDR32, IR32, PC32;
  logic BEN, BEN32;
  logic [2:0] NZP, NZP32;
  logic [11:0] LED, LED32;
`ifdef DATAPATH_BUSCHK_EN
  logic Bus_Err, Bus_Err32;
`endif
  int n_tests = 0, n_fail = 0;

  datapath_p #(.WIDTH(16), .PC_RESET(PCR), .LED_W(12)) dut (
    .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC),
    .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .MDR_In(MDR_In), .Bus(Bus), .MAR(MAR), .MDR(MDR), .IR(IR), .PC(PC), .BEN(BEN),
    .NZP(NZP), .LED(LED)
`ifdef DATAPATH_BUSCHK_EN
    , .Bus_Err(Bus_Err)
`endif
  );

  datapath_p #(.WIDTH(32), .PC_RESET(32'h0), .LED_W(12)) dut32 (
    .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC),
    .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .MDR_In(MDR_In32), .Bus(Bus32), .MAR(MAR32), .MDR(MDR32), .IR(IR32), .PC(PC32),
    .BEN(BEN32), .NZP(NZP32), .LED(LED32)
`ifdef DATAPATH_BUSCHK_EN
    , .Bus_Err(Bus_Err32)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model of the 16-bit instance, advanced once per clock by tick().
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [15:0] m_r [8];
  logic [2:0]  m_nzp;
  logic        m_ben;
  logic [11:0] m_led;

  function automatic logic [15:0] sx(input logic [15:0] v, input int n);
    logic [15:0] m;
    m = 16'((32'd1 << n) - 1);
    return (((v >> (n - 1)) & 16'd1) != 0) ? (v | ~m) : (v & m);
  endfunction

  function automatic logic [15:0] m_a();
    return m_r[SR1MUX ? m_ir[8:6] : m_ir[11:9]];
  endfunction

  function automatic logic [15:0] m_alu();
    logic [15:0] a, b;
    a = m_a();
    b = SR2MUX ? sx(m_ir, 5) : m_r[m_ir[2:0]];
    case (ALUK)
      2'd0: return a + b;
      2'd1: return a & b;
      2'd2: return ~a;
      default: return a;
    endcase
  endfunction

  function automatic logic [15:0] m_adder();
    logic [15:0] off;
    off = (ADDR2MUX == 2'd0) ? 16'd0 : sx(m_ir, (ADDR2MUX == 2'd1) ? 6 : (ADDR2MUX == 2'd2) ? 9 : 11);
    return (ADDR1MUX ? m_a() : m_pc) + off;
  endfunction

  function automatic logic [15:0] m_bus();
    if (GatePC) return m_pc;
    if (GateMDR) return m_mdr;
    if (GateALU) return m_alu();
    if (GateMARMUX) return m_adder();
    return 16'd0;
  endfunction

  task automatic model_reset();
    m_pc = PCR; m_ir = 0; m_mar = 0; m_mdr = 0; m_nzp = 3'b010; m_ben = 0; m_led = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
  endtask

  task automatic model_clock();
    logic [15:0] b, ad;
    b = m_bus();
    ad = m_adder();
    if (LD_BEN) m_ben = |(m_ir[11:9] & m_nzp);
    if (LD_LED) m_led = m_ir[11:0];
    if (LD_CC) m_nzp = b[15] ? 3'b100 : (b == 0) ? 3'b010 : 3'b001;
    if (LD_PC) m_pc = (PCMUX == 2'd0) ? m_pc + 16'd1 : (PCMUX == 2'd1) ? b : (PCMUX == 2'd2) ? ad : m_pc;
    if (LD_REG) m_r[DRMUX ? 3'd7 : m_ir[11:9]] = b;
    if (LD_MAR) m_mar = b;
    if (LD_MDR) m_mdr = MIO_EN ? MDR_In : b;
    if (LD_IR) m_ir = b;
  endtask

  task automatic clear_ctl();
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {PCMUX, ADDR2MUX, ALUK} = '0;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN} = '0;
    MDR_In = '0; MDR_In32 = '0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    clear_ctl();
    Reset = 1'b0;
    model_reset();
    #2;
    @(posedge Clk);
    #1 Reset = 1'b1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clear_ctl(); MIO_EN = 1; MDR_In = v[15:0]; MDR_In32 = v; LD_MDR = 1; tick(); clear_ctl();
  endtask

  task automatic load_ir(input logic [31:0] v);
    load_mdr(v); GateMDR = 1; LD_IR = 1; tick(); clear_ctl();
  endtask

  task automatic load_pc(input logic [31:0] v);
    load_mdr(v); GateMDR = 1; PCMUX = 2'd1; LD_PC = 1; tick(); clear_ctl();
  endtask

  task automatic load_reg(input logic [2:0] idx, input logic [31:0] v);
    load_ir({20'd0, idx, 9'd0}); load_mdr(v); GateMDR = 1; LD_REG = 1; tick(); clear_ctl();
  endtask

  task automatic test_reset();
    clear_ctl();
    Reset = 1'b1;
    #1 Reset = 1'b0;
    model_reset();
    #2;
    n_tests++; if (PC !== PCR) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", PC, PCR); end
    n_tests++; if (NZP !== 3'b010) begin n_fail++; $display("FAIL reset_nzp: got %b expected 010", NZP); end
    n_tests++; if ({BEN, IR, MAR, MDR, LED, Bus} !== '0) begin n_fail++;
      $display("FAIL reset_zero: got ben=%b ir=%h mar=%h mdr=%h led=%h bus=%h expected all 0", BEN, IR, MAR, MDR, LED, Bus); end
    n_tests++; if (PC32 !== 32'h0) begin n_fail++; $display("FAIL reset_pc32: got %h expected 0", PC32); end
    @(posedge Clk);
    #1 Reset = 1'b1;
  endtask

  task automatic test_add_nzp_ben();
    load_reg(3'd1, 32'hFFFE);
    GateMDR = 1; LD_CC = 1; tick(); clear_ctl();
    n_tests++; if (NZP !== 3'b100) begin n_fail++; $display("FAIL nzp_neg: got %b expected 100", NZP); end
    load_ir(32'h1262);
    GateALU = 1; LD_REG = 1; LD_CC = 1; SR1MUX = 1; SR2MUX = 1; ALUK = 2'd0; #1;
    n_tests++; if (Bus !== 16'h0000) begin n_fail++; $display("FAIL add_bus: got %h expected 0000", Bus); end
    tick(); clear_ctl();
    n_tests++; if (NZP !== 3'b010) begin n_fail++; $display("FAIL add_nzp: got %b expected 010", NZP); end
    GateALU = 1; SR1MUX = 1; ALUK = 2'd3; #1;
    n_tests++; if (Bus !== 16'h0000) begin n_fail++; $display("FAIL r1_written: got %h expected 0000", Bus); end
    load_mdr(32'h0400);
    GateMDR = 1; LD_IR = 1; LD_BEN = 1; tick(); clear_ctl();
    n_tests++; if ({BEN, IR} !== {1'b0, 16'h0400}) begin n_fail++; $display("FAIL ben_old_ir: got ben=%b ir=%h expected ben=0 ir=0400", BEN, IR); end
    LD_BEN = 1; tick(); clear_ctl();
    n_tests++; if (BEN !== 1'b1) begin n_fail++; $display("FAIL ben_set: got %b expected 1", BEN); end
  endtask

  task automatic test_addr_pc();
    load_pc(32'h3000);
    load_ir(32'h01FF);
    ADDR1MUX = 0; ADDR2MUX = 2'd2; PCMUX = 2'd2; LD_PC = 1; tick(); clear_ctl();
    n_tests++; if (PC !== 16'h2FFF) begin n_fail++; $display("FAIL pc_off9: got %h expected 2fff", PC); end
    GatePC = 1; LD_MAR = 1; LD_PC = 1; PCMUX = 2'd0; tick(); clear_ctl();
    n_tests++; if ({MAR, PC} !== {16'h2FFF, 16'h3000}) begin n_fail++; $display("FAIL gatepc_ldpc: got mar=%h pc=%h expected mar=2fff pc=3000", MAR, PC); end
    load_pc(32'hFFFF);
    PCMUX = 2'd0; LD_PC = 1; tick(); clear_ctl();
    n_tests++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h expected 0000", PC); end
  endtask

  task automatic test_mdr();
    load_pc(32'h1234);
    MIO_EN = 1; MDR_In = 16'hABCD; LD_MDR = 1; tick(); clear_ctl();
    n_tests++; if (MDR !== 16'hABCD) begin n_fail++; $display("FAIL mdr_mem: got %h expected abcd", MDR); end
    MIO_EN = 0; GatePC = 1; LD_MDR = 1; tick(); clear_ctl();
    n_tests++; if (MDR !== 16'h1234) begin n_fail++; $display("FAIL mdr_bus: got %h expected 1234", MDR); end
  endtask

  task automatic test_led();
    load_ir(32'hF5A3);
    load_mdr(32'h0111);
    GateMDR = 1; LD_IR = 1; LD_LED = 1; tick(); clear_ctl();
    n_tests++; if (LED !== 12'h5A3) begin n_fail++; $display("FAIL led_old_ir: got %h expected 5a3", LED); end
    LD_LED = 1; tick(); clear_ctl();
    n_tests++; if (LED !== 12'h111) begin n_fail++; $display("FAIL led_new_ir: got %h expected 111", LED); end
  endtask

  task automatic test_contention();
    load_pc(32'h4321);
    GatePC = 1; GateALU = 1; #1;
    n_tests++; if (Bus !== 16'h4321) begin n_fail++; $display("FAIL bus_priority: got %h expected 4321", Bus); end
`ifdef DATAPATH_BUSCHK_EN
    n_tests++; if (Bus_Err !== 1'b0) begin n_fail++; $display("FAIL bus_err_pre: got %b expected 0", Bus_Err); end
    tick(); clear_ctl(); tick();
    n_tests++; if (Bus_Err !== 1'b1) begin n_fail++; $display("FAIL bus_err_sticky: got %b expected 1", Bus_Err); end
    pulse_reset();
    n_tests++; if (Bus_Err !== 1'b0) begin n_fail++; $display("FAIL bus_err_reset: got %b expected 0", Bus_Err); end
`else
    tick(); clear_ctl();
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = 8'($urandom);
      {GatePC, GateMDR, GateALU, GateMARMUX} = 4'($urandom);
`ifdef DATAPATH_BUSCHK_EN
      if (!$onehot0({GatePC, GateMDR, GateALU, GateMARMUX})) {GatePC, GateMDR, GateALU, GateMARMUX} = 4'b0010;
`endif
      {PCMUX, ADDR2MUX, ALUK} = 6'($urandom);
      {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN} = 5'($urandom);
      MDR_In = 16'($urandom); MDR_In32 = $urandom;
      #1;
      n_tests++; if (Bus !== m_bus()) begin n_fail++; $display("FAIL rnd_bus[%0d]: got %h expected %h", it, Bus, m_bus()); end
      tick();
      n_tests++; if ({PC, IR, MAR, MDR} !== {m_pc, m_ir, m_mar, m_mdr}) begin n_fail++;
        $display("FAIL rnd_regs[%0d]: got pc=%h ir=%h mar=%h mdr=%h expected %h %h %h %h", it, PC, IR, MAR, MDR, m_pc, m_ir, m_mar, m_mdr); end
      n_tests++; if ({NZP, BEN, LED} !== {m_nzp, m_ben, m_led}) begin n_fail++;
        $display("FAIL rnd_flags[%0d]: got nzp=%b ben=%b led=%h expected %b %b %h", it, NZP, BEN, LED, m_nzp, m_ben, m_led); end
    end
    clear_ctl();
  endtask

  task automatic test_width32();
    pulse_reset();
    load_ir(32'h0010);
    GateALU = 1; SR1MUX = 1; SR2MUX = 1; ALUK = 2'd0; #1;
    n_tests++; if (Bus32 !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL w32_sext: got %h expected fffffff0", Bus32); end
    clear_ctl();
    load_reg(3'd1, 32'h7FFFFFFF);
    load_ir(32'h1261);
    GateALU = 1; SR1MUX = 1; SR2MUX = 1; ALUK = 2'd0; LD_CC = 1; #1;
    n_tests++; if (Bus32 !== 32'h80000000) begin n_fail++; $display("FAIL w32_add: got %h expected 80000000", Bus32); end
    tick(); clear_ctl();
    n_tests++; if (NZP32 !== 3'b100) begin n_fail++; $display("FAIL w32_nzp: got %b expected 100", NZP32); end
  endtask

  initial begin
    test_reset();
    test_add_nzp_ben();
    test_addr_pc();
    test_mdr();
    test_led();
    test_contention();
    test_random();
    test_width32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
